sample_frontend: RTL and testbench

SAMPLE_FRONTEND -- requirements
Module: sample_frontend

---
 rtl/sample_frontend_if.sv | 24 ++
 rtl/sample_frontend.sv | 130 +++++++++++++
 tb/tb_sample_frontend.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_frontend_if.sv
// Codec-side and consumer-side handshake bundle for sample_frontend.
// The slave modport is the frontend's view of the bundle, and the master modport is the view of the codec and consumer that drive it.
interface sample_frontend_if #(
    parameter int N = 16
);
    logic                codecReady;
    logic signed [23:0]  leftIn;
    logic signed [23:0]  rightIn;
    logic                codecRead;
    logic signed [N-1:0] sampleOut;
    logic                sampleReady;
    logic                doingRead;
    logic [7:0]          overrunCount;

    modport master (
        output codecReady, leftIn, rightIn, doingRead,
        input  codecRead, sampleOut, sampleReady, overrunCount
    );

    modport slave (
        input  codecReady, leftIn, rightIn, doingRead,
        output codecRead, sampleOut, sampleReady, overrunCount
    );
endinterface

// File: rtl/sample_frontend.sv
// Stereo codec frontend: sums L+R, averages 2^DECIM_LOG2 frames, saturates, and holds the result for the DFT.
// Optional DC-blocking stage is enabled with macro SAMPLE_FRONTEND_DC_BLOCK_EN.
module sample_frontend #(
    parameter int N          = 16,
    parameter int DECIM_LOG2 = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    sample_frontend_if.slave bus
);
    localparam int AW = 25 + DECIM_LOG2;
    localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

    typedef enum logic [1:0] {IDLE, ACK, SUM} state_t;

    state_t                state_q;
    logic signed [24:0]    frame_q;
    logic signed [AW-1:0]  acc_q;
    logic [CW-1:0]         cnt_q;
    logic                  codec_read_q;
    logic                  pub_q;
    logic                  ready_q;
    logic signed [N-1:0]   out_q;
    logic [7:0]            ovr_q;

    logic signed [AW-1:0]  acc_sum;
    logic signed [AW-1:0]  avg;
    logic signed [23:0]    avg_sat;
    logic signed [23:0]    cond_sat;
    logic signed [N-1:0]   out_d;
    logic                  wrap;
    logic                  load;

    function automatic logic signed [23:0] sat24(input logic signed [32:0] v);
        if (v > 33'sd8388607)
            return 24'sh7FFFFF;
        else if (v < -33'sd8388608)
            return 24'sh800000;
        else
            return v[23:0];
    endfunction

    always_comb begin
        acc_sum = acc_q + AW'(frame_q);
        avg     = acc_sum >>> DECIM_LOG2;
        avg_sat = sat24(33'(avg));
        wrap    = (DECIM_LOG2 == 0) || (cnt_q == '1);
        load    = (state_q == SUM) && wrap;
    end

`ifdef SAMPLE_FRONTEND_DC_BLOCK_EN
    // dc is 24.8 fixed point; y is formed at the same scale so dc tracks with a 256-load time constant.
    logic signed [31:0] dc_q;
    logic signed [31:0] dc_d;
    logic signed [32:0] y_fx;
    logic signed [32:0] y_int;

    always_comb begin
        y_fx     = 33'($signed({avg_sat, 8'h00})) - 33'(dc_q);
        y_int    = y_fx >>> 8;
        dc_d     = dc_q + 32'(y_int);
        cond_sat = sat24(y_int);
    end
`else
    assign cond_sat = avg_sat;
`endif

    assign out_d = cond_sat[23:24-N];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            codec_read_q <= 1'b0;
            pub_q        <= 1'b0;
            ready_q      <= 1'b0;
            out_q        <= '0;
            ovr_q        <= '0;
`ifdef SAMPLE_FRONTEND_DC_BLOCK_EN
            dc_q         <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.codecReady) begin
                        frame_q      <= 25'(bus.leftIn) + 25'(bus.rightIn);
                        codec_read_q <= 1'b1;
                        state_q      <= ACK;
                    end
                end
                ACK: begin
                    codec_read_q <= 1'b0;
                    state_q      <= SUM;
                end
                SUM: begin
                    state_q <= IDLE;
                    cnt_q   <= wrap ? '0 : cnt_q + 1'b1;
                    if (wrap) begin
                        acc_q <= '0;
                        out_q <= out_d;
`ifdef SAMPLE_FRONTEND_DC_BLOCK_EN
                        dc_q  <= dc_d;
`endif
                    end else begin
                        acc_q <= acc_sum;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A read on the load edge took the old sample; otherwise an unread sample is overwritten.
            pub_q <= load;
            if (load && ready_q && !bus.doingRead && ovr_q != 8'hFF)
                ovr_q <= ovr_q + 8'd1;

            if (ready_q && bus.doingRead)
                ready_q <= 1'b0;
            else if (pub_q)
                ready_q <= 1'b1;
        end
    end

    assign bus.codecRead    = codec_read_q;
    assign bus.sampleOut    = out_q;
    assign bus.sampleReady  = ready_q;
    assign bus.overrunCount = ovr_q;
endmodule

// File: tb/tb_sample_frontend.sv
// Directed self-checking bench for sample_frontend: one instance with no decimation, one averaging four frames.
// With SAMPLE_FRONTEND_DC_BLOCK_EN defined it runs the DC-blocking convergence scenario instead of the value tests.
module tb_sample_frontend;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    sample_frontend_if #(.N(16)) bus0 ();
    sample_frontend_if #(.N(16)) bus2 ();

    sample_frontend #(.N(16), .DECIM_LOG2(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    sample_frontend #(.N(16), .DECIM_LOG2(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic rdy, input logic [23:0] l, input logic [23:0] r);
        if (which == 0) begin
            bus0.codecReady = rdy; bus0.leftIn = l; bus0.rightIn = r;
        end else begin
            bus2.codecReady = rdy; bus2.leftIn = l; bus2.rightIn = r;
        end
    endtask

    task automatic set_read(input int which, input logic v);
        if (which == 0) bus0.doingRead = v;
        else            bus2.doingRead = v;
    endtask

    function automatic logic get_ready(input int which);
        return (which == 0) ? bus0.sampleReady : bus2.sampleReady;
    endfunction

    function automatic logic [15:0] get_out(input int which);
        return (which == 0) ? bus0.sampleOut : bus2.sampleOut;
    endfunction

    // One codec frame: IDLE sees codecReady, then ACK, then SUM.
    task automatic frame(input int which, input logic [23:0] l, input logic [23:0] r);
        drive(which, 1'b1, l, r);
        step();
        drive(which, 1'b0, l, r);
        step();
        step();
    endtask

    task automatic consume(input int which);
        set_read(which, 1'b1);
        step();
        set_read(which, 1'b0);
    endtask

    task automatic wait_ready(input int which, input string tag);
        int k;
        k = 0;
        while (!get_ready(which) && k < 10) begin
            step();
            k++;
        end
        n_cmp++;
        if (get_ready(which) !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: sampleReady=%b want 1 within 10 cycles", tag, get_ready(which));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 24'h0, 24'h0);
        drive(2, 1'b0, 24'h0, 24'h0);
        set_read(0, 1'b0);
        set_read(2, 1'b0);
        step();
        step();
        n_cmp++;
        if ({bus0.codecRead, bus0.sampleReady, bus0.sampleOut, bus0.overrunCount} !== 26'h0) begin
            n_err++;
            $display("FAIL reset_dut0: rd=%b rdy=%b out=%h ovr=%0d want all 0",
                     bus0.codecRead, bus0.sampleReady, bus0.sampleOut, bus0.overrunCount);
        end
        n_cmp++;
        if ({bus2.codecRead, bus2.sampleReady, bus2.sampleOut, bus2.overrunCount} !== 26'h0) begin
            n_err++;
            $display("FAIL reset_dut2: rd=%b rdy=%b out=%h ovr=%0d want all 0",
                     bus2.codecRead, bus2.sampleReady, bus2.sampleOut, bus2.overrunCount);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        drive(0, 1'b1, 24'h000100, 24'h000200);
        step();
        drive(0, 1'b0, 24'h0, 24'h0);
        n_cmp++;
        if (bus0.codecRead !== 1'b1) begin n_err++; $display("FAIL basic_read_ack: got %b want 1", bus0.codecRead); end
        step();
        n_cmp++;
        if (bus0.codecRead !== 1'b0) begin n_err++; $display("FAIL basic_read_sum: got %b want 0", bus0.codecRead); end
        step();
        n_cmp++;
        if (bus0.sampleReady !== 1'b0) begin n_err++; $display("FAIL basic_ready_early: got %b want 0", bus0.sampleReady); end
        step();
        n_cmp++;
        if (bus0.sampleReady !== 1'b1) begin n_err++; $display("FAIL basic_ready_lat3: got %b want 1", bus0.sampleReady); end
        n_cmp++;
        if (bus0.sampleOut !== 16'h0003) begin n_err++; $display("FAIL basic_out: got %h want 0003", bus0.sampleOut); end
        n_cmp++;
        if (bus0.codecRead !== 1'b0) begin n_err++; $display("FAIL basic_read_idle: got %b want 0", bus0.codecRead); end
        consume(0);
        n_cmp++;
        if (bus0.sampleReady !== 1'b0) begin n_err++; $display("FAIL basic_consume: rdy=%b want 0", bus0.sampleReady); end
        consume(0);
        step();
        step();
        n_cmp++;
        if (bus0.sampleReady !== 1'b0 || bus0.sampleOut !== 16'h0003) begin
            n_err++;
            $display("FAIL basic_idle_hold: rdy=%b out=%h want 0 / 0003", bus0.sampleReady, bus0.sampleOut);
        end
    endtask

    task automatic test_saturation();
        frame(0, 24'h7FFFFF, 24'h7FFFFF);
        wait_ready(0, "sat_pos");
        n_cmp++;
        if (bus0.sampleOut !== 16'h7FFF) begin n_err++; $display("FAIL sat_pos: got %h want 7fff", bus0.sampleOut); end
        consume(0);
        frame(0, 24'h800000, 24'h800000);
        wait_ready(0, "sat_neg");
        n_cmp++;
        if (bus0.sampleOut !== 16'h8000) begin n_err++; $display("FAIL sat_neg: got %h want 8000", bus0.sampleOut); end
        consume(0);
        frame(0, 24'hFFFF00, 24'hFFFE00);
        wait_ready(0, "neg_small");
        n_cmp++;
        if (bus0.sampleOut !== 16'hFFFD) begin n_err++; $display("FAIL neg_small: got %h want fffd", bus0.sampleOut); end
        consume(0);
    endtask

    task automatic test_decim();
        logic [23:0] l_tab [4];
        l_tab = '{24'h000200, 24'h000200, 24'h000400, 24'h000400};
        for (int i = 0; i < 4; i++) begin
            frame(2, l_tab[i], l_tab[i]);
            step();
            if (i < 3) begin
                n_cmp++;
                if (bus2.sampleReady !== 1'b0) begin
                    n_err++;
                    $display("FAIL decim_early_%0d: rdy=%b want 0", i, bus2.sampleReady);
                end
            end
        end
        n_cmp++;
        if (bus2.sampleReady !== 1'b1 || bus2.sampleOut !== 16'h0006) begin
            n_err++;
            $display("FAIL decim_out: rdy=%b out=%h want 1 / 0006", bus2.sampleReady, bus2.sampleOut);
        end
        consume(2);
    endtask

    task automatic test_overrun();
        frame(0, 24'h000080, 24'h000080);
        frame(0, 24'h000100, 24'h000100);
        frame(0, 24'h000180, 24'h000180);
        step();
        n_cmp++;
        if (bus0.sampleReady !== 1'b1) begin n_err++; $display("FAIL ovr_ready: got %b want 1", bus0.sampleReady); end
        n_cmp++;
        if (bus0.overrunCount !== 8'd2) begin n_err++; $display("FAIL ovr_count: got %0d want 2", bus0.overrunCount); end
        n_cmp++;
        if (bus0.sampleOut !== 16'h0003) begin n_err++; $display("FAIL ovr_last: got %h want 0003", bus0.sampleOut); end
    endtask

    // Load edge coincides with a read of the pending sample: no overrun, new sample presented.
    task automatic test_back_to_back();
        drive(0, 1'b1, 24'h000200, 24'h000200);
        step();
        drive(0, 1'b0, 24'h0, 24'h0);
        step();
        set_read(0, 1'b1);
        step();
        set_read(0, 1'b0);
        step();
        n_cmp++;
        if (bus0.sampleReady !== 1'b1 || bus0.sampleOut !== 16'h0004) begin
            n_err++;
            $display("FAIL b2b_new: rdy=%b out=%h want 1 / 0004", bus0.sampleReady, bus0.sampleOut);
        end
        n_cmp++;
        if (bus0.overrunCount !== 8'd2) begin n_err++; $display("FAIL b2b_ovr: got %0d want 2", bus0.overrunCount); end
        consume(0);
    endtask

    task automatic test_reset_mid();
        frame(2, 24'h004000, 24'h004000);
        frame(2, 24'h004000, 24'h004000);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus2.codecRead, bus2.sampleReady, bus2.sampleOut, bus2.overrunCount} !== 26'h0) begin
            n_err++;
            $display("FAIL rstmid_dut2: rd=%b rdy=%b out=%h ovr=%0d want all 0",
                     bus2.codecRead, bus2.sampleReady, bus2.sampleOut, bus2.overrunCount);
        end
        n_cmp++;
        if (bus0.sampleOut !== 16'h0 || bus0.overrunCount !== 8'd0) begin
            n_err++;
            $display("FAIL rstmid_dut0: out=%h ovr=%0d want 0 / 0", bus0.sampleOut, bus0.overrunCount);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame(2, 24'h000200, 24'h000200);
            step();
            if (i < 3) begin
                n_cmp++;
                if (bus2.sampleReady !== 1'b0) begin
                    n_err++;
                    $display("FAIL rstmid_early_%0d: rdy=%b want 0", i, bus2.sampleReady);
                end
            end
        end
        n_cmp++;
        if (bus2.sampleReady !== 1'b1 || bus2.sampleOut !== 16'h0004) begin
            n_err++;
            $display("FAIL rstmid_out: rdy=%b out=%h want 1 / 0004", bus2.sampleReady, bus2.sampleOut);
        end
        consume(2);
    endtask

    task automatic test_dc_block();
        logic signed [15:0] v;
        frame(0, 24'h008000, 24'h008000);
        step();
        n_cmp++;
        if (bus0.sampleOut !== 16'h0100) begin n_err++; $display("FAIL dc_first: got %h want 0100", bus0.sampleOut); end
        for (int i = 1; i < 4096; i++)
            frame(0, 24'h008000, 24'h008000);
        step();
        v = bus0.sampleOut;
        n_cmp++;
        if (!(v < 16'sd2 && v > -16'sd2)) begin
            n_err++;
            $display("FAIL dc_settle: got %0d want magnitude below 2", v);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
`ifdef SAMPLE_FRONTEND_DC_BLOCK_EN
        test_dc_block();
`else
        test_basic();
        test_saturation();
        test_decim();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
